alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL provide clock__i, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL provide reset_n__i, input, 1: asynchronous, active-low reset.
REQ-003 SHALL provide OpValid__i, input, 1: an operation is offered this cycle.
REQ-004 SHALL provide OpReady__o, output, 1: block accepts the offered operation this cycle.
REQ-005 SHALL provide ALUCtrl__i, input, 3: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 110 SUB, 111 SLT, 101 illegal.
REQ-006 SHALL provide OperandA__i and OperandB__i, input, 32 each: source operands.
REQ-007 SHALL provide ResValid__o, output, 1: head result entry is valid.
REQ-008 SHALL provide ResReady__i, input, 1: consumer takes the head entry this cycle.
REQ-009 SHALL provide Result__o, output, 32: head entry result.
REQ-010 SHALL provide Zero__o, output, 1: head entry result equals 0.
REQ-011 SHALL provide IllegalOp__o, output, 1: head entry came from ALUCtrl 101.
REQ-012 SHALL provide Overflow__o, output, 1, only when ALU_EXEC_OVF_EN is defined: head entry signed overflow.

Function
REQ-013 SHALL accept an operation when OpValid__i and OpReady__o are both high at a rising edge; no other condition accepts.
REQ-014 SHALL drop a result entry when ResValid__o and ResReady__i are both high at a rising edge.
REQ-015 SHALL hold results in a 2-entry in-order buffer with occupancy states EMPTY, ONE, FULL.
REQ-016 SHALL drive OpReady__o = 1 in EMPTY and ONE and 0 in FULL. OpReady__o is a function of state only, with no combinational path from ResReady__i.
REQ-017 SHALL drive ResValid__o = 1 in ONE and FULL and 0 in EMPTY.
REQ-018 SHALL transition: EMPTY+accept->ONE. ONE+accept only->FULL. ONE+drop only->EMPTY. ONE+accept+drop->ONE. FULL+drop->ONE. Otherwise hold.
REQ-019 SHALL have latency 1: an op accepted at edge N into EMPTY shows ResValid__o=1 with its result after edge N.
REQ-020 SHALL compute AND, OR, XOR, NOR bitwise; ADD/SUB modulo 2^32. SUB is A-B.
REQ-021 SHALL compute SLT as 32'd1 when A<B signed, else 32'd0. The comparison uses the true sign of the subtraction, correct under overflow.
REQ-022 SHALL, for ALUCtrl 101, store Result 0, Zero 1, IllegalOp 1. The entry is still accepted and delivered.
REQ-023 SHALL compute Zero from the stored result, not from live operands.
REQ-024 SHALL preserve result order; in ONE with accept+drop, the old head leaves and the new op becomes head.
REQ-025 SHALL keep head outputs stable while ResValid__o=1 and ResReady__i=0.
REQ-026 SHALL drive Result__o, Zero__o, IllegalOp__o (and Overflow__o) to 0 while in EMPTY.
REQ-027 SHALL ignore ALUCtrl__i and operands when no accept occurs.

Reset
REQ-028 SHALL, on reset_n__i low, immediately enter EMPTY and clear both entries, regardless of any in-flight handshake.
REQ-029 SHALL present reset outputs OpReady__o=1, ResValid__o=0, and all data/flag outputs 0.
REQ-030 SHALL not accept or drop any entry at a rising edge while reset_n__i is low.

Configuration
REQ-031 SHALL, with ALU_EXEC_OVF_EN defined, store a per-entry overflow bit and expose Overflow__o.
REQ-032 Under ALU_EXEC_OVF_EN, the overflow bit SHALL be 1 on ADD when the operand signs match and the result sign differs. On SUB it SHALL be 1 when the operand signs differ and the result sign differs from A. It SHALL be 0 for all other codes.
REQ-033 SHALL, without ALU_EXEC_OVF_EN, omit the Overflow__o port and all overflow storage; all other behaviour is identical.

Verification
REQ-034 Reset then ADD A=5,B=7 accepted, ResReady__i=1 -> next cycle ResValid__o=1, Result__o=12, Zero__o=0, then EMPTY.
REQ-035 Hold ResReady__i=0, offer SUB 9-9, OR 0xF0|0x0F, XOR 1^1 -> first two accepted, OpReady__o=0 on third. Release: heads 0 (Zero 1), then 0xFF; third then accepted -> 0 (Zero 1).
REQ-036 SLT A=0x80000000,B=1 -> 1. SLT A=0x7FFFFFFF,B=0xFFFFFFFF -> 0. NOR 0,0 -> 0xFFFFFFFF.
REQ-037 In ONE, accept AND 0xC,0xA with simultaneous drop -> state stays ONE, head becomes 8.
REQ-038 ALUCtrl 101 -> Result 0, Zero 1, IllegalOp 1. With ALU_EXEC_OVF_EN: ADD 0x7FFFFFFF+1 -> 0x80000000, Overflow 1.
REQ-039 Assert reset_n__i low mid-cycle while FULL -> outputs clear asynchronously before next edge. OpReady__o=1, ResValid__o=0.

Source files
------------

// File: rtl/alu_exec.sv
// Single-cycle ALU feeding a 2-entry in-order result buffer with valid/ready on both sides.
// Optional per-entry signed-overflow flag and Overflow__o port when ALU_EXEC_OVF_EN is defined.
module alu_exec (
   input  logic        clock__i,
   input  logic        reset_n__i,
   input  logic        OpValid__i,
   output logic        OpReady__o,
   input  logic [2:0]  ALUCtrl__i,
   input  logic [31:0] OperandA__i,
   input  logic [31:0] OperandB__i,
   output logic        ResValid__o,
   input  logic        ResReady__i,
   output logic [31:0] Result__o,
   output logic        Zero__o,
   output logic        IllegalOp__o
`ifdef ALU_EXEC_OVF_EN
   ,
   output logic        Overflow__o
`endif
);

`ifdef ALU_EXEC_OVF_EN
   localparam int unsigned FlagW = 2;  // {overflow, illegal}
`else
   localparam int unsigned FlagW = 1;  // {illegal}
`endif

   typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

   state_e           r_state;
   logic [31:0]      r_res0;
   logic [31:0]      r_res1;
   logic [FlagW-1:0] r_flag0;
   logic [FlagW-1:0] r_flag1;

   logic             w_accept;
   logic             w_drop;
   logic [31:0]      w_sum;
   logic [31:0]      w_diff;
   logic             w_sub_ovf;
   logic [31:0]      w_res;
   logic             w_illegal;
   logic [FlagW-1:0] w_flag;

   assign OpReady__o  = (r_state != StFull);
   assign ResValid__o = (r_state != StEmpty);
   assign w_accept    = OpValid__i & OpReady__o;
   assign w_drop      = ResValid__o & ResReady__i;

   assign w_sum     = OperandA__i + OperandB__i;
   assign w_diff    = OperandA__i - OperandB__i;
   assign w_sub_ovf = (OperandA__i[31] ^ OperandB__i[31]) & (w_diff[31] ^ OperandA__i[31]);

   always_comb begin
      w_res     = '0;
      w_illegal = 1'b0;
      case (ALUCtrl__i)
         3'b000:  w_res = OperandA__i & OperandB__i;
         3'b001:  w_res = OperandA__i | OperandB__i;
         3'b010:  w_res = w_sum;
         3'b011:  w_res = OperandA__i ^ OperandB__i;
         3'b100:  w_res = ~(OperandA__i | OperandB__i);
         3'b110:  w_res = w_diff;
         // True sign of A-B: the raw sign bit is inverted exactly when the subtraction overflows
         3'b111:  w_res = {31'd0, w_diff[31] ^ w_sub_ovf};
         default: w_illegal = 1'b1;
      endcase
   end

`ifdef ALU_EXEC_OVF_EN
   logic w_add_ovf;
   logic w_ovf;
   assign w_add_ovf = ~(OperandA__i[31] ^ OperandB__i[31]) & (w_sum[31] ^ OperandA__i[31]);
   assign w_ovf     = ((ALUCtrl__i == 3'b010) & w_add_ovf) | ((ALUCtrl__i == 3'b110) & w_sub_ovf);
   assign w_flag    = {w_ovf, w_illegal};
`else
   assign w_flag    = w_illegal;
`endif

   // Entry 0 is always the head; entry 1 only holds data in StFull
   always_ff @(posedge clock__i or negedge reset_n__i) begin
      if (!reset_n__i) begin
         r_state <= StEmpty;
         r_res0  <= '0;
         r_res1  <= '0;
         r_flag0 <= '0;
         r_flag1 <= '0;
      end else begin
         case (r_state)
            StEmpty: begin
               if (w_accept) begin
                  r_res0  <= w_res;
                  r_flag0 <= w_flag;
                  r_state <= StOne;
               end
            end
            StOne: begin
               if (w_accept && w_drop) begin
                  r_res0  <= w_res;
                  r_flag0 <= w_flag;
               end else if (w_accept) begin
                  r_res1  <= w_res;
                  r_flag1 <= w_flag;
                  r_state <= StFull;
               end else if (w_drop) begin
                  r_state <= StEmpty;
               end
            end
            StFull: begin
               if (w_drop) begin
                  r_res0  <= r_res1;
                  r_flag0 <= r_flag1;
                  r_state <= StOne;
               end
            end
            default: r_state <= StEmpty;
         endcase
      end
   end

   assign Result__o    = ResValid__o ? r_res0 : 32'd0;
   assign Zero__o      = ResValid__o & (r_res0 == 32'd0);
   assign IllegalOp__o = ResValid__o & r_flag0[0];
`ifdef ALU_EXEC_OVF_EN
   assign Overflow__o  = ResValid__o & r_flag0[FlagW-1];
`endif

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: vector table through the empty buffer, plus handshake,
// back-pressure and asynchronous reset sequences.
module tb_alu_exec;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        op_valid = 1'b0;
   logic        res_ready = 1'b0;
   logic [2:0]  ctrl = 3'b000;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        op_ready;
   logic        res_valid;
   logic [31:0] result;
   logic        zero;
   logic        illegal;
`ifdef ALU_EXEC_OVF_EN
   logic        ovf;
`endif

   int n_checks = 0;
   int n_errors = 0;

   alu_exec dut (
      .clock__i     (clk),
      .reset_n__i   (rst_n),
      .OpValid__i   (op_valid),
      .OpReady__o   (op_ready),
      .ALUCtrl__i   (ctrl),
      .OperandA__i  (a),
      .OperandB__i  (b),
      .ResValid__o  (res_valid),
      .ResReady__i  (res_ready),
      .Result__o    (result),
      .Zero__o      (zero),
      .IllegalOp__o (illegal)
`ifdef ALU_EXEC_OVF_EN
      ,
      .Overflow__o  (ovf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        zero;
      logic        ill;
      logic        ovf;
   } vec_t;

   vec_t vecs [18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_empty(input string tag);
      check({tag, " op_ready"}, {31'd0, op_ready}, 32'd1);
      check({tag, " res_valid"}, {31'd0, res_valid}, 32'd0);
      check({tag, " result"}, result, 32'd0);
      check({tag, " zero"}, {31'd0, zero}, 32'd0);
      check({tag, " illegal"}, {31'd0, illegal}, 32'd0);
`ifdef ALU_EXEC_OVF_EN
      check({tag, " ovf"}, {31'd0, ovf}, 32'd0);
`endif
   endtask

   task automatic offer(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
      op_valid = 1'b1;
      ctrl     = c;
      a        = x;
      b        = y;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = {3'b010, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1'b0};
      vecs[1]  = {3'b110, 32'd9,          32'd9,          32'd0,          1'b1, 1'b0, 1'b0};
      vecs[2]  = {3'b001, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0, 1'b0};
      vecs[3]  = {3'b011, 32'd1,          32'd1,          32'd0,          1'b1, 1'b0, 1'b0};
      vecs[4]  = {3'b111, 32'h8000_0000, 32'd1,          32'd1,          1'b0, 1'b0, 1'b0};
      vecs[5]  = {3'b111, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0,          1'b1, 1'b0, 1'b0};
      vecs[6]  = {3'b100, 32'd0,          32'd0,          32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
      vecs[7]  = {3'b000, 32'h0000_000C, 32'h0000_000A, 32'd8,          1'b0, 1'b0, 1'b0};
      vecs[8]  = {3'b101, 32'd5,          32'd3,          32'd0,          1'b1, 1'b1, 1'b0};
      vecs[9]  = {3'b110, 32'd3,          32'd5,          32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
      vecs[10] = {3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1,          1'b0, 1'b0, 1'b0};
      vecs[11] = {3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0,          1'b1, 1'b0, 1'b0};
      vecs[12] = {3'b010, 32'h7FFF_FFFF, 32'd1,          32'h8000_0000, 1'b0, 1'b0, 1'b1};
      vecs[13] = {3'b110, 32'h8000_0000, 32'd1,          32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1};
      vecs[14] = {3'b010, 32'hFFFF_FFFF, 32'd1,          32'd0,          1'b1, 1'b0, 1'b0};
      vecs[15] = {3'b100, 32'hFFFF_FFFF, 32'd0,          32'd0,          1'b1, 1'b0, 1'b0};
      vecs[16] = {3'b111, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1,          1'b0, 1'b0, 1'b0};
      vecs[17] = {3'b111, 32'd5,          32'd5,          32'd0,          1'b1, 1'b0, 1'b0};

      // Reset state
      #12;
      check_empty("in_reset");
      rst_n = 1'b1;
      tick();
      check_empty("after_reset");

      // No accept while OpValid is low, whatever the operands
      offer(3'b010, 32'd1, 32'd1);
      op_valid = 1'b0;
      tick();
      check_empty("idle_ignore");

      // Table: accept into EMPTY with consumer ready, result after one edge, then drained
      res_ready = 1'b1;
      for (int i = 0; i < 18; i++) begin
         offer(vecs[i].ctrl, vecs[i].a, vecs[i].b);
         tick();
         op_valid = 1'b0;
         check($sformatf("vec%0d res_valid", i), {31'd0, res_valid}, 32'd1);
         check($sformatf("vec%0d op_ready", i), {31'd0, op_ready}, 32'd1);
         check($sformatf("vec%0d result", i), result, vecs[i].res);
         check($sformatf("vec%0d zero", i), {31'd0, zero}, {31'd0, vecs[i].zero});
         check($sformatf("vec%0d illegal", i), {31'd0, illegal}, {31'd0, vecs[i].ill});
`ifdef ALU_EXEC_OVF_EN
         check($sformatf("vec%0d ovf", i), {31'd0, ovf}, {31'd0, vecs[i].ovf});
`endif
         tick();
         check($sformatf("vec%0d drained", i), {31'd0, res_valid}, 32'd0);
         check($sformatf("vec%0d empty_result", i), result, 32'd0);
      end
      res_ready = 1'b0;

      // Back-pressure: fill to FULL, third op stalls, then drain in order
      offer(3'b110, 32'd9, 32'd9);
      tick();
      check("bp one head", result, 32'd0);
      check("bp one zero", {31'd0, zero}, 32'd1);
      offer(3'b001, 32'h0000_00F0, 32'h0000_000F);
      tick();
      check("bp full op_ready", {31'd0, op_ready}, 32'd0);
      check("bp full head", result, 32'd0);
      offer(3'b011, 32'd1, 32'd1);
      tick();
      check("bp stall op_ready", {31'd0, op_ready}, 32'd0);
      check("bp stall head", result, 32'd0);
      check("bp stall zero", {31'd0, zero}, 32'd1);
      res_ready = 1'b1;
      tick();
      check("bp second head", result, 32'h0000_00FF);
      check("bp second zero", {31'd0, zero}, 32'd0);
      check("bp second op_ready", {31'd0, op_ready}, 32'd1);
      tick();
      op_valid = 1'b0;
      check("bp third valid", {31'd0, res_valid}, 32'd1);
      check("bp third head", result, 32'd0);
      check("bp third zero", {31'd0, zero}, 32'd1);
      tick();
      check("bp drained", {31'd0, res_valid}, 32'd0);
      res_ready = 1'b0;

      // Accept and drop on the same edge in ONE: new op becomes head, stays ONE
      offer(3'b010, 32'd1, 32'd1);
      tick();
      check("swap first head", result, 32'd2);
      offer(3'b000, 32'h0000_000C, 32'h0000_000A);
      res_ready = 1'b1;
      tick();
      op_valid = 1'b0;
      check("swap head", result, 32'd8);
      check("swap res_valid", {31'd0, res_valid}, 32'd1);
      check("swap op_ready", {31'd0, op_ready}, 32'd1);
      tick();
      check("swap drained", {31'd0, res_valid}, 32'd0);
      res_ready = 1'b0;

      // Asynchronous reset mid-cycle while FULL, held across an edge with handshakes offered
      offer(3'b101, 32'd4, 32'd4);
      tick();
      offer(3'b010, 32'd1, 32'd2);
      tick();
      check("rst pre op_ready", {31'd0, op_ready}, 32'd0);
      check("rst pre illegal", {31'd0, illegal}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_empty("rst_async");
      res_ready = 1'b1;
      tick();
      check_empty("rst_held");
      rst_n = 1'b1;
      op_valid = 1'b0;
      tick();
      check_empty("rst_released");
      res_ready = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
